// File: rtl/pipelined_csel_adder_if.sv
// Operand/result stream bundle for pipelined_csel_adder.
// The ovf signal exists only when CSEL_ADDER_OVF_EN is defined.
interface pipelined_csel_adder_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             cout;
`ifdef CSEL_ADDER_OVF_EN
    logic             ovf;

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, out_sum, cout, ovf
    );
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, out_sum, cout, ovf
    );
`else
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, out_sum, cout
    );
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, out_sum, cout
    );
`endif
endinterface

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor, one BLK-bit block per stage, valid/ready stream.
// Optional signed-overflow output enabled by defining CSEL_ADDER_OVF_EN.
module pipelined_csel_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BLK   = 8
) (
    input logic                   clk,
    input logic                   rst,
    pipelined_csel_adder_if.slave io_bus
);
    localparam int unsigned NBLK = (BLK == 0) ? 1 : WIDTH / BLK;

    if (BLK < 1) begin : g_bad_blk
        $error("pipelined_csel_adder: BLK must be at least 1");
    end else if ((WIDTH % BLK) != 0) begin : g_bad_width
        $error("pipelined_csel_adder: WIDTH must be a multiple of BLK");
    end

    logic w_en;

    assign w_en            = ~g_stage[NBLK-1].r_vld | io_bus.out_ready;
    assign io_bus.in_ready = w_en;

    for (genvar k = 0; k < NBLK; k++) begin : g_stage
        localparam int unsigned OPW = WIDTH - k * BLK;
        localparam int unsigned SW  = (k + 1) * BLK;

        logic [OPW-1:0] w_a_in;
        logic [OPW-1:0] w_bb_in;
        logic           w_c_in;
        logic           w_v_in;
        logic [BLK:0]   w_s0;
        logic [BLK:0]   w_s1;
        logic [BLK:0]   w_sel;
        logic [SW-1:0]  w_sum_d;
        logic [SW-1:0]  r_sum;
        logic           r_c;
        logic           r_vld;

        // Stage 0 folds subtraction into inverted B and inverted borrow-in.
        if (k == 0) begin : g_head
            assign w_a_in  = io_bus.a;
            assign w_bb_in = io_bus.sub ? ~io_bus.b : io_bus.b;
            assign w_c_in  = io_bus.sub ^ io_bus.cin;
            assign w_v_in  = io_bus.in_valid;
            assign w_sum_d = w_sel[BLK-1:0];
        end else begin : g_body
            assign w_a_in  = g_stage[k-1].g_op.r_a;
            assign w_bb_in = g_stage[k-1].g_op.r_bb;
            assign w_c_in  = g_stage[k-1].r_c;
            assign w_v_in  = g_stage[k-1].r_vld;
            assign w_sum_d = {w_sel[BLK-1:0], g_stage[k-1].r_sum};
        end

        assign w_s0  = {1'b0, w_a_in[BLK-1:0]} + {1'b0, w_bb_in[BLK-1:0]};
        assign w_s1  = {1'b0, w_a_in[BLK-1:0]} + {1'b0, w_bb_in[BLK-1:0]}
                     + {{BLK{1'b0}}, 1'b1};
        assign w_sel = w_c_in ? w_s1 : w_s0;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld <= 1'b0;
                r_c   <= 1'b0;
                r_sum <= '0;
            end else if (w_en) begin
                r_vld <= w_v_in;
                r_c   <= w_sel[BLK];
                r_sum <= w_sum_d;
            end
        end

        // Skew registers for the operand blocks that later stages still need.
        if (k < NBLK - 1) begin : g_op
            logic [OPW-BLK-1:0] r_a;
            logic [OPW-BLK-1:0] r_bb;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a  <= '0;
                    r_bb <= '0;
                end else if (w_en) begin
                    r_a  <= w_a_in[OPW-1:BLK];
                    r_bb <= w_bb_in[OPW-1:BLK];
                end
            end
        end
    end

    assign io_bus.out_valid = g_stage[NBLK-1].r_vld;
    assign io_bus.out_sum   = g_stage[NBLK-1].r_sum;
    assign io_bus.cout      = g_stage[NBLK-1].r_c;

`ifdef CSEL_ADDER_OVF_EN
    logic r_sa;
    logic r_sbb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sa  <= 1'b0;
            r_sbb <= 1'b0;
        end else if (w_en) begin
            r_sa  <= g_stage[NBLK-1].w_a_in[BLK-1];
            r_sbb <= g_stage[NBLK-1].w_bb_in[BLK-1];
        end
    end

    assign io_bus.ovf = (r_sa == r_sbb) & (g_stage[NBLK-1].r_sum[WIDTH-1] != r_sa);
`endif
endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Self-checking bench for pipelined_csel_adder (WIDTH=32, BLK=8) with an arithmetic model.
// Overflow checks are compiled in when CSEL_ADDER_OVF_EN is defined.
module tb_pipelined_csel_adder;
    localparam int unsigned W  = 32;
    localparam int unsigned B  = 8;
    localparam int unsigned NB = W / B;

    typedef struct packed {
        logic         ovf;
        logic         cout;
        logic [W-1:0] sum;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    res_t exp_q[$];

    always #5 clk = ~clk;

    pipelined_csel_adder_if #(.WIDTH(W)) bus ();

    pipelined_csel_adder #(.WIDTH(W), .BLK(B)) dut (
        .clk   (clk),
        .rst   (rst),
        .io_bus(bus)
    );

    // Reference: plain signed/unsigned integer arithmetic on A and B.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic s);
        longint ua, ub, sa, sb, c, r, sr, smax, smin;
        res_t   e;
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        c    = ci ? 64'sd1 : 64'sd0;
        smax = (longint'(1) <<< (W - 1)) - 1;
        smin = -(longint'(1) <<< (W - 1));
        r    = s ? (ua - ub - c) : (ua + ub + c);
        sr   = s ? (sa - sb - c) : (sa + sb + c);
        e.sum  = r[W-1:0];
        e.cout = s ? (r >= 0) : (r >= (longint'(1) <<< W));
        e.ovf  = (sr > smax) || (sr < smin);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic s);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = ci;
        bus.sub      = s;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.out_ready = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
        end
        checks++;
        if (bus.out_sum !== '0) begin
            failures++; $display("FAIL reset_out_sum got=%h want=0", bus.out_sum);
        end
        checks++;
        if (bus.cout !== 1'b0) begin
            failures++; $display("FAIL reset_cout got=%b want=0", bus.cout);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
        end
`ifdef CSEL_ADDER_OVF_EN
        checks++;
        if (bus.ovf !== 1'b0) begin
            failures++; $display("FAIL reset_ovf got=%b want=0", bus.ovf);
        end
`endif
    endtask

    // Checks exact latency: out_valid low after edges t..t+NB-2, high after t+NB-1.
    task automatic test_cross_block();
        logic [W-1:0] ta [2];
        logic [W-1:0] tb [2];
        logic         tc [2];
        logic [W-1:0] es [2];
        logic         ec [2];
        ta = '{32'h000000FF, 32'hFFFFFFFF};
        tb = '{32'h00000001, 32'h00000001};
        tc = '{1'b1, 1'b0};
        es = '{32'h00000101, 32'h00000000};
        ec = '{1'b0, 1'b1};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, ta[i], tb[i], tc[i], 1'b0);
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                failures++; $display("FAIL xblk_in_ready[%0d] got=%b want=1", i, bus.in_ready);
            end
            tick();
            drive(1'b0, '0, '0, 1'b0, 1'b0);
            for (int c = 0; c < NB; c++) begin
                if (c > 0) tick();
                checks++;
                if (bus.out_valid !== (c == NB - 1)) begin
                    failures++;
                    $display("FAIL xblk_latency[%0d] edge+%0d got=%b want=%b",
                             i, c, bus.out_valid, (c == NB - 1));
                end
            end
            checks++;
            if (bus.out_sum !== es[i]) begin
                failures++; $display("FAIL xblk_sum[%0d] got=%h want=%h", i, bus.out_sum, es[i]);
            end
            checks++;
            if (bus.cout !== ec[i]) begin
                failures++; $display("FAIL xblk_cout[%0d] got=%b want=%b", i, bus.cout, ec[i]);
            end
            tick();
        end
    endtask

    task automatic test_subtract();
        logic [W-1:0] ta [2];
        logic [W-1:0] tb [2];
        logic         tc [2];
        logic [W-1:0] es [2];
        logic         ec [2];
        int           n;
        ta = '{32'd5, 32'd7};
        tb = '{32'd7, 32'd5};
        tc = '{1'b0, 1'b1};
        es = '{32'hFFFFFFFE, 32'h00000001};
        ec = '{1'b0, 1'b1};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, ta[i], tb[i], tc[i], 1'b1);
            tick();
            drive(1'b0, '0, '0, 1'b0, 1'b0);
            n = 0;
            while (bus.out_valid !== 1'b1 && n < 10) begin
                tick();
                n++;
            end
            checks++;
            if (bus.out_valid !== 1'b1) begin
                failures++; $display("FAIL sub_timeout[%0d] got=%b want=1", i, bus.out_valid);
            end
            checks++;
            if (bus.out_sum !== es[i]) begin
                failures++; $display("FAIL sub_sum[%0d] got=%h want=%h", i, bus.out_sum, es[i]);
            end
            checks++;
            if (bus.cout !== ec[i]) begin
                failures++; $display("FAIL sub_cout[%0d] got=%b want=%b", i, bus.cout, ec[i]);
            end
`ifdef CSEL_ADDER_OVF_EN
            checks++;
            if (bus.ovf !== 1'b0) begin
                failures++; $display("FAIL sub_ovf[%0d] got=%b want=0", i, bus.ovf);
            end
`endif
            tick();
        end
    endtask

`ifdef CSEL_ADDER_OVF_EN
    task automatic test_overflow();
        logic [W-1:0] ta [2];
        logic         ts [2];
        logic [W-1:0] es [2];
        int           n;
        ta = '{32'h7FFFFFFF, 32'h80000000};
        ts = '{1'b0, 1'b1};
        es = '{32'h80000000, 32'h7FFFFFFF};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, ta[i], 32'd1, 1'b0, ts[i]);
            tick();
            drive(1'b0, '0, '0, 1'b0, 1'b0);
            n = 0;
            while (bus.out_valid !== 1'b1 && n < 10) begin
                tick();
                n++;
            end
            checks++;
            if (bus.out_sum !== es[i]) begin
                failures++; $display("FAIL ovf_sum[%0d] got=%h want=%h", i, bus.out_sum, es[i]);
            end
            checks++;
            if (bus.ovf !== 1'b1) begin
                failures++; $display("FAIL ovf_flag[%0d] got=%b want=1", i, bus.ovf);
            end
            if (i == 0) begin
                checks++;
                if (bus.cout !== 1'b0) begin
                    failures++; $display("FAIL ovf_cout got=%b want=0", bus.cout);
                end
            end
            tick();
        end
    endtask
`endif

    task automatic test_back_to_back();
        int   sent = 0;
        int   got = 0;
        bit   gap = 1'b0;
        res_t e;
        exp_q.delete();
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 8 + NB + 6; cyc++) begin
            if (sent < 8) drive(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)),
                                1'($urandom_range(0, 1)));
            else drive(1'b0, '0, '0, 1'b0, 1'b0);
            #1;
            if (bus.out_valid === 1'b1) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                checks++;
                if (bus.out_sum !== e.sum || bus.cout !== e.cout) begin
                    failures++;
                    $display("FAIL stream_beat[%0d] got=%h/%b want=%h/%b",
                             got, bus.out_sum, bus.cout, e.sum, e.cout);
                end
`ifdef CSEL_ADDER_OVF_EN
                checks++;
                if (bus.ovf !== e.ovf) begin
                    failures++; $display("FAIL stream_ovf[%0d] got=%b want=%b", got, bus.ovf, e.ovf);
                end
`endif
                got++;
            end else if (got > 0 && got < 8) begin
                gap = 1'b1;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
                sent++;
            end
            tick();
        end
        checks++;
        if (got != 8) begin
            failures++; $display("FAIL stream_count got=%0d want=8", got);
        end
        checks++;
        if (gap) begin
            failures++; $display("FAIL stream_gap got=1 want=0");
        end
    endtask

    task automatic test_backpressure();
        int           sent = 0;
        int           got = 0;
        int           stall_left = 0;
        bit           stall_done = 1'b0;
        logic [W-1:0] ca, cb;
        logic         cc, cs;
        res_t         e;
        exp_q.delete();
        ca = $urandom; cb = $urandom;
        cc = 1'($urandom_range(0, 1)); cs = 1'($urandom_range(0, 1));
        for (int cyc = 0; cyc < 12 + NB + 16; cyc++) begin
            drive(sent < 12, ca, cb, cc, cs);
            if (!stall_done && stall_left == 0 && bus.out_valid === 1'b1 && got >= 2)
                stall_left = 3;
            bus.out_ready = (stall_left == 0);
            #1;
            if (stall_left > 0) begin
                e = (exp_q.size() > 0) ? exp_q[0] : '0;
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    failures++; $display("FAIL bp_in_ready got=%b want=0", bus.in_ready);
                end
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_sum !== e.sum || bus.cout !== e.cout) begin
                    failures++;
                    $display("FAIL bp_hold got=%b/%h/%b want=1/%h/%b",
                             bus.out_valid, bus.out_sum, bus.cout, e.sum, e.cout);
                end
                stall_left--;
                if (stall_left == 0) stall_done = 1'b1;
            end
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                checks++;
                if (bus.out_sum !== e.sum || bus.cout !== e.cout) begin
                    failures++;
                    $display("FAIL bp_beat[%0d] got=%h/%b want=%h/%b",
                             got, bus.out_sum, bus.cout, e.sum, e.cout);
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(ca, cb, cc, cs));
                sent++;
                ca = $urandom; cb = $urandom;
                cc = 1'($urandom_range(0, 1)); cs = 1'($urandom_range(0, 1));
            end
            tick();
        end
        checks++;
        if (!stall_done) begin
            failures++; $display("FAIL bp_stall_seen got=0 want=1");
        end
        checks++;
        if (got != 12 || exp_q.size() != 0) begin
            failures++; $display("FAIL bp_count got=%0d left=%0d want=12 left=0", got, exp_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        exp_q.delete();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, $urandom, 1'b0, 1'b0);
            tick();
        end
        // Beat presented alongside reset must be dropped.
        drive(1'b1, 32'h12345678, 32'h11111111, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_sum !== '0) begin
            failures++;
            $display("FAIL rst_mid_clear got=%b/%h want=0/0", bus.out_valid, bus.out_sum);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b0) begin
                failures++; $display("FAIL rst_mid_stale[%0d] got=%b want=0", c, bus.out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cross_block();
        test_subtract();
`ifdef CSEL_ADDER_OVF_EN
        test_overflow();
`endif
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
